// File: rtl/sync_debounce_pkg.sv
// Shared helpers for the sync_debounce block.
package sync_debounce_pkg;

  // Counter width able to hold DEBOUNCE_CYCLES without wrapping.
  function automatic int unsigned cnt_width(input int unsigned debounce_cycles);
    return (debounce_cycles < 1) ? 1 : $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// One channel: N-flop synchronizer, consecutive-sample debounce filter, edge pulses.
module sync_debounce_channel
  import sync_debounce_pkg::*;
#(
  parameter int unsigned STAGES          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic        RESET_BIT       = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [STAGES-1:0] sync_q;
  logic              s;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              out_q, out_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  assign s = sync_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= {STAGES{RESET_BIT}};
      cnt_q  <= '0;
      out_q  <= RESET_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in};
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // Any agreeing sample clears the run, so only consecutive disagreements count.
  always_comb begin
    cnt_d  = '0;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s != out_q) begin
      if (cnt_q == CntMax) begin
        out_d  = s;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchronizer + debounce + edge detect for async inputs entering clk.
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int unsigned     WIDTH           = 1,
  parameter int unsigned     STAGES          = 2,
  parameter int unsigned     DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_debounce: STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("sync_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_debounce_channel #(
      .STAGES          (STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_BIT       (RESET_VALUE[i])
    ) u_ch (
      .clk    (clk),
      .resetn (resetn),
      .in     (in[i]),
      .out    (out[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: default build plus a STAGES=3/DEBOUNCE=1/reset-high variant.
module tb_sync_debounce;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] din, dout, rise, fall;
  logic [3:0] din_v, dout_v, rise_v, fall_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_debounce #(
    .WIDTH           (4),
    .STAGES          (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_VALUE     (4'h0)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .in     (din),
    .out    (dout),
    .rise   (rise),
    .fall   (fall)
  );

  sync_debounce #(
    .WIDTH           (4),
    .STAGES          (3),
    .DEBOUNCE_CYCLES (1),
    .RESET_VALUE     (4'hF)
  ) dut_v (
    .clk    (clk),
    .resetn (resetn),
    .in     (din_v),
    .out    (dout_v),
    .rise   (rise_v),
    .fall   (fall_v)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    din    = 4'h0;
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  int rc[4];
  int rc2, fc2;

  initial begin
    resetn = 1'b0;
    din    = 4'hF;
    din_v  = 4'hF;

    // 1: reset held 5 edges with inputs high, then normal latency to out.
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("rst_out", dout, 4'h0);
      check("rst_rise", rise, 4'h0);
      check("rst_fall", fall, 4'h0);
    end
    check("rst_out_v", dout_v, 4'hF);
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) rc[c] = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check("rel_out", dout, (e >= 6) ? 4'hF : 4'h0);
      check("rel_rise", rise, (e == 6) ? 4'hF : 4'h0);
      check("rel_fall", fall, 4'h0);
      for (int c = 0; c < 4; c++) rc[c] += int'(rise[c]);
    end
    for (int c = 0; c < 4; c++) check("rel_rise_count", rc[c], 1);

    // 2: clean step on channel 0.
    do_reset();
    din = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("step_out", dout, (e >= 6) ? 4'h1 : 4'h0);
      check("step_rise", rise, (e == 6) ? 4'h1 : 4'h0);
    end

    // 3: 3-cycle glitch is rejected, 4-cycle pulse is accepted then released.
    do_reset();
    din = 4'b0010;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 3) din = 4'h0;
      check("glitch3_out", dout, 4'h0);
      check("glitch3_rise", rise, 4'h0);
    end
    din = 4'b0010;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 4) din = 4'h0;
      check("glitch4_out", dout[1], (e >= 6 && e <= 9));
      check("glitch4_rise", rise[1], (e == 6));
      check("glitch4_fall", fall[1], (e == 10));
    end

    // 4: bounce for 10 edges, settled 1 first sampled at edge 11 -> out at edge 16.
    do_reset();
    rc2 = 0;
    fc2 = 0;
    for (int k = 1; k <= 20; k++) begin
      din[2] = (k <= 10) ? logic'(k % 2) : 1'b1;
      tick();
      rc2 += int'(rise[2]);
      fc2 += int'(fall[2]);
      if (k == 15) check("bounce_out_pre", dout, 4'h0);
      if (k == 16) begin
        check("bounce_out", dout, 4'h4);
        check("bounce_rise", rise, 4'h4);
      end
    end
    check("bounce_rise_count", rc2, 1);
    check("bounce_fall_count", fc2, 0);

    // 5: parallel inputs with a one-edge reset mid-count.
    do_reset();
    din = 4'b1010;
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    check("midrst_out", dout, 4'h0);
    check("midrst_rise", rise, 4'h0);
    check("midrst_fall", fall, 4'h0);
    resetn = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("par_out", dout, (e >= 6) ? 4'hA : 4'h0);
      check("par_rise", rise, (e == 6) ? 4'hA : 4'h0);
      check("par_fall", fall, 4'h0);
    end

    // 6: variant, in[3] 1->0 sampled at edge 1 -> fall at edge 4.
    check("var_idle_out", dout_v, 4'hF);
    din_v = 4'h7;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("var_out", dout_v, (e >= 4) ? 4'h7 : 4'hF);
      check("var_fall", fall_v, (e == 4) ? 4'h8 : 4'h0);
      check("var_rise", rise_v, 4'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Multi-bit successor to the single-bit `synchronizer`.
- Each of WIDTH asynchronous inputs passes through an N-stage synchronizer, then a consecutive-cycle debounce filter, then an edge detector.
- Used for pushbuttons, switches and external async status lines entering the clk domain.
- Outputs a clean level plus one-cycle rise/fall pulses per channel.

Parameters:
- WIDTH, 1, number of independent channels.
- STAGES, 2, synchronizer flop depth; must be >= 2, otherwise elaboration error.
- DEBOUNCE_CYCLES, 4, consecutive cycles a new synchronized value must persist before it is accepted; must be >= 1, otherwise elaboration error.
- RESET_VALUE, '0, WIDTH-bit value loaded into synchronizer stages and out on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetn  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in  input  WIDTH  asynchronous inputs; no timing relation to clk.
- out  output  WIDTH  debounced, synchronized level.
- rise  output  WIDTH  one-cycle pulse when out[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse when out[i] goes 1->0.

Behaviour:
- Reset: resetn is synchronous, active-low.
  - When resetn=0 at a rising edge, every synchronizer stage[i] <= RESET_VALUE[i], out <= RESET_VALUE, counters <= 0, rise <= 0, fall <= 0.
  - No rise/fall pulse is generated by reset assertion or release.
  - Reset mid-debounce discards the partial count.
- Channels are fully independent; no cross-channel interaction.
- Synchronizer: shift register of STAGES flops per channel; s[i] is the last stage. No logic between stages.
- Debounce, per channel, evaluated each rising edge with resetn=1:
  - s[i] == out[i]: cnt[i] <= 0, out[i] holds.
  - s[i] != out[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s[i] != out[i] and cnt[i] == DEBOUNCE_CYCLES-1: out[i] <= s[i], cnt[i] <= 0.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1); it never wraps.
- Glitch rejection: a disagreement lasting fewer than DEBOUNCE_CYCLES consecutive edges resets the count and leaves out unchanged. Count restarts from 0 on the next disagreement.
- Latency: if in[i] changes and is sampled at edge 1 (first flop), s[i] updates at edge STAGES and out[i] updates at edge STAGES+DEBOUNCE_CYCLES. With defaults, that is edge 6.
- Edges:
  - rise[i] and fall[i] are registered and assert in the same cycle out[i] takes its new value, for exactly one cycle.
  - rise and fall are never both high on one channel.
  - Back-to-back accepted transitions are separated by at least DEBOUNCE_CYCLES cycles.
- DEBOUNCE_CYCLES=1: out follows s with one register delay and no filtering; pulses are still generated.
- All outputs are driven directly from flops (no combinational path from in).
- Metastability: only the first stage may go metastable. The block guarantees no behaviour for an input toggling faster than clk, other than that out never changes without DEBOUNCE_CYCLES consistent samples.

Decomposition:
- No shared typedefs required.
- Parameter legality checks live in the module as elaboration-time assertions.
- Natural sub-module: sync_debounce_channel.
  - Single-bit synchronizer chain, counter, out/rise/fall flops.
  - Parameters STAGES, DEBOUNCE_CYCLES, RESET_BIT.
  - Instantiated WIDTH times in a generate loop.
- The existing `synchronizer` is not reused, because STAGES must be parametric.

Test Plan (WIDTH=4, STAGES=2, DEBOUNCE_CYCLES=4, RESET_VALUE=4'b0000 unless noted):
1. Reset: hold resetn=0 for 5 edges with in=4'hF, release -> out=0, rise=fall=0 during reset and on the release edge; after release out[i] rises only via normal latency, with a single rise pulse per channel.
2. Clean step: in[0] 0->1 sampled at edge 1 -> out[0]=1 and rise[0]=1 after edge 6; rise[0]=0 after edge 7; other channels unchanged.
3. Glitch: in[1] high for exactly 3 clk periods, then low -> out[1] stays 0, no rise[1]. Repeat with 4 periods -> out[1]=1, rise[1] pulse, then fall[1] pulse 4 cycles after s[1] returns low.
4. Bounce: in[2] toggles every cycle for 10 cycles, then settles at 1 -> exactly one rise[2], no fall[2]; out[2]=1 at settle edge + 6.
5. Parallel/mid-reset: in=4'b1010 applied together, resetn=0 pulsed for 1 edge at cycle 4 (mid-count) -> after reset out=0 with no pulses; counting restarts, and out=4'b1010 with rise=4'b1010 at edge 6 after reset release.
6. Param variants: STAGES=3, DEBOUNCE_CYCLES=1, RESET_VALUE=4'hF -> out=4'hF after reset; in[3] 1->0 gives out[3]=0 and fall[3]=1 at edge 4.
